// File: rtl/controlador_memoria_pkg.sv
// controlador_memoria_pkg: shared FSM state type and memory geometry defaults
package controlador_memoria_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} estado_t;
  localparam int DATA_W_DEF = 32;
  localparam int MEM_AW_DEF = 7;
  localparam int MEM_DEPTH = 2 ** MEM_AW_DEF;
endpackage

// File: rtl/contador_saturado.sv
// contador_saturado: enable-driven up counter that sticks at its maximum value
module contador_saturado #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] q
);
  always_ff @(posedge clk)
    q <= rst ? '0 : (en && !(&q)) ? q + 1'b1 : q;
endmodule

// File: rtl/controlador_memoria.sv
// controlador_memoria: single-outstanding valid/ready initiator for the 128x32 memory
module controlador_memoria
  import controlador_memoria_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MEM_AW = MEM_AW_DEF,
  parameter int REQ_AW = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [REQ_AW-1:0] req_endereco,
  input  logic [DATA_W-1:0] req_dado,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_dado,
  output logic              resp_erro,
  output logic [DATA_W-1:0] mem_dado,
  output logic [MEM_AW-1:0] mem_endereco,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_saida,
  output logic [CNT_W-1:0]  n_leituras,
  output logic [CNT_W-1:0]  n_escritas
);
  estado_t estado, prox;
  logic req_ready_d, resp_valid_d, resp_erro_d, mem_write_d;
  logic [DATA_W-1:0] resp_dado_d, mem_dado_d;
  logic [MEM_AW-1:0] mem_endereco_d;
  logic fora;
  assign fora = |req_endereco[REQ_AW-1:MEM_AW];
  always_comb begin
    prox = estado;
    req_ready_d = req_ready;
    resp_valid_d = resp_valid;
    resp_dado_d = resp_dado;
    resp_erro_d = resp_erro;
    mem_write_d = 1'b0;
    mem_endereco_d = mem_endereco;
    mem_dado_d = mem_dado;
    case (estado)
      IDLE: if (req_valid) begin
        req_ready_d = 1'b0;
        mem_endereco_d = req_endereco[MEM_AW-1:0];
        prox = fora ? RESP : req_write ? WRITE : READ;
        resp_valid_d = fora;
        resp_erro_d = fora;
        resp_dado_d = fora ? '0 : resp_dado;
        mem_write_d = !fora && req_write;
        mem_dado_d = (!fora && req_write) ? req_dado : mem_dado;
      end
      WRITE: begin
        prox = RESP;
        resp_valid_d = 1'b1;
        resp_erro_d = 1'b0;
        resp_dado_d = '0;
      end
      READ: begin
        prox = RESP;
        resp_valid_d = 1'b1;
        resp_erro_d = 1'b0;
        resp_dado_d = mem_saida;
      end
      RESP: if (resp_ready) begin
        prox = IDLE;
        resp_valid_d = 1'b0;
        req_ready_d = 1'b1;
      end
      default: prox = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      estado <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_dado <= '0;
      resp_erro <= 1'b0;
      mem_write <= 1'b0;
      mem_endereco <= '0;
      mem_dado <= '0;
    end else begin
      estado <= prox;
      req_ready <= req_ready_d;
      resp_valid <= resp_valid_d;
      resp_dado <= resp_dado_d;
      resp_erro <= resp_erro_d;
      mem_write <= mem_write_d;
      mem_endereco <= mem_endereco_d;
      mem_dado <= mem_dado_d;
    end
  end
  // counters advance on the closing edge of the single READ/WRITE cycle
  contador_saturado #(.W(CNT_W)) u_leituras (
    .clk(clk), .rst(rst), .en(estado == READ), .q(n_leituras)
  );
  contador_saturado #(.W(CNT_W)) u_escritas (
    .clk(clk), .rst(rst), .en(estado == WRITE), .q(n_escritas)
  );
endmodule

// File: tb/tb_controlador_memoria.sv
// tb_controlador_memoria: directed checks of the controller against a behavioural 128x32 memory
module tb_controlador_memoria;
  import controlador_memoria_pkg::*;
  logic clk = 1'b0;
  logic rst, req_valid, req_write, resp_ready;
  logic [31:0] req_endereco, req_dado;
  logic req_ready, resp_valid, resp_erro, mem_write;
  logic [31:0] resp_dado, mem_dado, mem_saida;
  logic [6:0] mem_endereco;
  logic [15:0] n_leituras, n_escritas;
  logic [31:0] mem [0:MEM_DEPTH-1];
  int checks = 0, errors = 0, pulsos = 0, cyc = 0;

  controlador_memoria dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_endereco(req_endereco), .req_dado(req_dado),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dado(resp_dado),
    .resp_erro(resp_erro), .mem_dado(mem_dado), .mem_endereco(mem_endereco),
    .mem_write(mem_write), .mem_saida(mem_saida),
    .n_leituras(n_leituras), .n_escritas(n_escritas)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (mem_write) mem[mem_endereco] <= mem_dado;
  always @(negedge clk) mem_saida <= mem[mem_endereco];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) pulsos <= pulsos + 1;
  end

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, esp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic espera_ready;
    int n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    if (!req_ready) verifica("timeout_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic transacao(input logic w, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] dado, output logic erro);
    espera_ready();
    req_valid = 1'b1; req_write = w; req_endereco = a; req_dado = d;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin tick(); lat++; end
    dado = resp_dado;
    erro = resp_erro;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, p0, ruins, ultimo;
    logic [31:0] dado;
    logic erro, estavel;
    for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
    mem[55] = 32'd1;
    mem[56] = 32'd2;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_endereco = '0; req_dado = '0;
    resp_ready = 1'b1;
    tick(); tick();
    verifica("rst_req_ready", 32'(req_ready), 32'd1);
    verifica("rst_resp_valid", 32'(resp_valid), 32'd0);
    verifica("rst_resp_dado", resp_dado, 32'd0);
    verifica("rst_resp_erro", 32'(resp_erro), 32'd0);
    verifica("rst_mem_write", 32'(mem_write), 32'd0);
    verifica("rst_mem_endereco", 32'(mem_endereco), 32'd0);
    verifica("rst_mem_dado", mem_dado, 32'd0);
    verifica("rst_counters", {n_leituras, n_escritas}, 32'd0);
    rst = 1'b0;
    tick();

    transacao(1'b1, 32'd60, 32'hDEADBEEF, lat, dado, erro);
    verifica("t1_wr_lat", 32'(lat), 32'd2);
    verifica("t1_wr_erro", 32'(erro), 32'd0);
    verifica("t1_wr_dado", dado, 32'd0);
    transacao(1'b0, 32'd60, 32'd0, lat, dado, erro);
    verifica("t1_rd_lat", 32'(lat), 32'd2);
    verifica("t1_rd_dado", dado, 32'hDEADBEEF);
    verifica("t1_rd_erro", 32'(erro), 32'd0);
    verifica("t1_n_escritas", 32'(n_escritas), 32'd1);
    verifica("t1_n_leituras", 32'(n_leituras), 32'd1);

    p0 = pulsos;
    transacao(1'b0, 32'd55, 32'd0, lat, dado, erro);
    verifica("t2_rd55", dado, 32'd1);
    transacao(1'b0, 32'd56, 32'd0, lat, dado, erro);
    verifica("t2_rd56", dado, 32'd2);
    verifica("t2_no_write", 32'(pulsos - p0), 32'd0);

    transacao(1'b0, 32'd200, 32'd0, lat, dado, erro);
    verifica("t3_lat", 32'(lat), 32'd1);
    verifica("t3_erro", 32'(erro), 32'd1);
    verifica("t3_dado", dado, 32'd0);
    verifica("t3_no_write", 32'(pulsos - p0), 32'd0);
    verifica("t3_counters", {n_leituras, n_escritas}, {16'd3, 16'd1});

    resp_ready = 1'b0;
    espera_ready();
    req_valid = 1'b1; req_write = 1'b0; req_endereco = 32'd56;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin tick(); lat++; end
    req_valid = 1'b1; req_write = 1'b1; req_endereco = 32'd5; req_dado = 32'hBAD0BAD0;
    estavel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (!(resp_valid === 1'b1 && resp_dado === 32'd2 && req_ready === 1'b0)) estavel = 1'b0;
      tick();
    end
    verifica("t4_held_stable", 32'(estavel), 32'd1);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    verifica("t4_resp_valid_drop", 32'(resp_valid), 32'd0);
    verifica("t4_req_ready_back", 32'(req_ready), 32'd1);
    verifica("t4_ignored_req", 32'(pulsos - p0), 32'd0);
    verifica("t4_n_escritas", 32'(n_escritas), 32'd1);

    espera_ready();
    req_valid = 1'b1; req_write = 1'b1; req_endereco = 32'd10; req_dado = 32'h12345678;
    tick();
    req_valid = 1'b0;
    verifica("t5_mem_write_in_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    verifica("t5_resp_valid", 32'(resp_valid), 32'd0);
    verifica("t5_req_ready", 32'(req_ready), 32'd1);
    verifica("t5_mem_write", 32'(mem_write), 32'd0);
    verifica("t5_mem_endereco", 32'(mem_endereco), 32'd0);
    verifica("t5_mem_dado", mem_dado, 32'd0);
    verifica("t5_counters", {n_leituras, n_escritas}, 32'd0);
    tick();
    verifica("t5_no_resp", 32'(resp_valid), 32'd0);
    transacao(1'b0, 32'd10, 32'd0, lat, dado, erro);
    verifica("t5_rd10", dado, 32'h12345678);

    p0 = pulsos;
    ruins = 0;
    ultimo = -1;
    req_valid = 1'b1; req_write = 1'b1;
    for (int i = 0; i < 20; i++) begin
      espera_ready();
      req_endereco = 32'(70 + i);
      req_dado = 32'(i * 3);
      if (ultimo >= 0 && cyc - ultimo != 3) ruins++;
      ultimo = cyc;
      tick();
    end
    req_valid = 1'b0;
    espera_ready();
    verifica("t6_accept_spacing", 32'(ruins), 32'd0);
    verifica("t6_write_pulses", 32'(pulsos - p0), 32'd20);
    verifica("t6_n_escritas", 32'(n_escritas), 32'd20);
    transacao(1'b0, 32'd75, 32'd0, lat, dado, erro);
    verifica("t6_rd75", dado, 32'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
